hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller for the 5-stage MIPS core. Drives hold/clear inputs of
//  the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers (sync hold/clear, clear wins).
//  Handles load-use stall, taken-branch flush, multi-cycle mul/div stall and data-memory wait.
//  Control outputs are Mealy (state + current inputs), so the registers sample them on the same edge.
// PARAMETERS
//  MD_LAT   4    total stall cycles for a mul/div op in EX; legal range >= 2
//  MEM_TO   16   consecutive memory-wait cycles before mem_err is set
// PORTS
//  clk             in   1   core clock, all state on posedge
//  rst_n           in   1   asynchronous active-low reset
//  id_rs           in   5   rs of instruction in ID
//  id_rt           in   5   rt of instruction in ID
//  ex_rt           in   5   destination (rt) of instruction in EX
//  ex_memread      in   1   EX instruction is a load
//  ex_branch_taken in   1   branch/jump in EX resolved taken
//  ex_md           in   1   EX instruction is mul/div; level, held while the op sits in EX
//  mem_req         in   1   MEM-stage access in progress
//  mem_ready       in   1   data memory completes access this cycle
//  pc_hold         out  1   freeze PC
//  ifid_hold/ifid_clear      out 1 each  IF/ID register control
//  idex_hold/idex_clear      out 1 each  ID/EX register control
//  exmem_hold/exmem_clear    out 1 each  EX/MEM register control
//  memwb_clear     out  1   inject bubble into WB
//  mem_err         out  1   sticky memory-timeout flag
//  stall_cycles    out  32  count of cycles with pc_hold=1, saturates at 32'hFFFF_FFFF
// BEHAVIOUR
//  Reset (rst_n=0): state=RUN, md_cnt=0, md_done=0, wait_cnt=0, mem_err=0, stall_cycles=0.
//   While rst_n=0, all *_clear=1 and all holds=0.
//  Default output (no hazard): all holds and clears 0.
//  Conditions, evaluated each cycle, highest priority first:
//   1 MEMW: mem_req && !mem_ready.
//     Outputs: pc_hold, ifid_hold, idex_hold, exmem_hold = 1; memwb_clear = 1.
//     All lower conditions are suppressed; the md_cnt decrement pauses.
//   2 MD: state=MD_WAIT, or (state=RUN && ex_md && !md_done).
//     Outputs: pc_hold, ifid_hold, idex_hold = 1; exmem_clear = 1.
//   3 BR: ex_branch_taken. Outputs: ifid_clear = 1, idex_clear = 1; PC not held.
//   4 LU: ex_memread && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt).
//     Outputs: pc_hold, ifid_hold = 1; idex_clear = 1. Lasts exactly one cycle.
//  FSM states: RUN, MD_WAIT.
//   RUN -> MD_WAIT when MD fires in RUN and MEMW is not active; md_cnt <= MD_LAT-2.
//   MD_WAIT, not MEMW: md_cnt == 0 -> RUN with md_done <= 1; otherwise md_cnt--.
//   md_done is cleared on the next non-MEMW cycle. It masks the still-high ex_md for one
//    cycle so the op leaves EX.
//   Net effect: exactly MD_LAT stall cycles per mul/div op, excluding MEMW cycles.
//  Memory timeout: wait_cnt increments on MEMW cycles and clears on any non-MEMW cycle.
//   When wait_cnt reaches MEM_TO-1 while MEMW is active, mem_err <= 1.
//   mem_err stays set until reset.
//  stall_cycles increments on every posedge where pc_hold = 1, and holds at all-ones.
//  Async reset mid-MD_WAIT or mid-MEMW aborts to RUN immediately; no pending stall survives.
// TESTING
//  T1 lw $5 in EX, id_rs=5 -> exactly 1 cycle of pc_hold=ifid_hold=idex_clear=1, then all 0.
//  T2 lw with ex_rt=0 and id_rs=0 -> no stall.
//  T3 ex_branch_taken=1 together with load-use -> ifid_clear=idex_clear=1, pc_hold=0.
//  T4 ex_md held high, MD_LAT=4 -> exmem_clear=1 for 4 cycles.
//     Next cycle has no stall; stall_cycles += 4.
//  T5 MEMW for 3 cycles in the middle of MD_WAIT -> MD total stall = 4+3 cycles.
//     In those 3 cycles exmem_hold=1 and exmem_clear=0.
//  T6 mem_ready held low for 16 cycles -> mem_err=1 at the 16th edge.
//     Pulse rst_n low -> all state and stall_cycles return to 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage MIPS core.
// Produces Mealy hold/clear controls for the IF/ID, ID/EX, EX/MEM and MEM/WB
// registers so they act on the same edge the hazard is seen. It covers the
// data-memory wait, the multi-cycle mul/div stall, the taken-branch flush and
// the load-use stall, in that priority order.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   id_rs, id_rt                source registers of the instruction in ID
//   ex_rt, ex_memread           destination / load flag of the instruction in EX
//   ex_branch_taken             branch in EX resolved taken
//   ex_md                       mul/div in EX (level, held while the op sits in EX)
//   mem_req, mem_ready          MEM-stage access in progress / completing
//   pc_hold, *_hold, *_clear    pipeline register controls (combinational)
//   mem_err                     sticky memory-timeout flag
//   stall_cycles                saturating count of pc_hold cycles
module hazard_ctrl #(
    parameter int unsigned MD_LAT = 4,
    parameter int unsigned MEM_TO = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  ex_rt,
    input  logic        ex_memread,
    input  logic        ex_branch_taken,
    input  logic        ex_md,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_hold,
    output logic        ifid_hold,
    output logic        ifid_clear,
    output logic        idex_hold,
    output logic        idex_clear,
    output logic        exmem_hold,
    output logic        exmem_clear,
    output logic        memwb_clear,
    output logic        mem_err,
    output logic [31:0] stall_cycles
);

    localparam int unsigned MCW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
    localparam int unsigned WCW = $clog2(MEM_TO) + 1;

    typedef enum logic [0:0] {ST_RUN, ST_MD_WAIT} state_t;

    state_t           state;
    logic [MCW-1:0]   md_cnt;
    logic             md_done;
    logic [WCW-1:0]   wait_cnt;

    logic memw_c, md_c, br_c, lu_c;

    // Hazard detection
    assign memw_c = mem_req && !mem_ready;
    assign md_c   = (state == ST_MD_WAIT) || ((state == ST_RUN) && ex_md && !md_done);
    assign br_c   = ex_branch_taken;
    assign lu_c   = ex_memread && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

    // Prioritised Mealy controls; reset flushes every stage
    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_clear  = 1'b0;
        idex_hold   = 1'b0;
        idex_clear  = 1'b0;
        exmem_hold  = 1'b0;
        exmem_clear = 1'b0;
        memwb_clear = 1'b0;
        if (!rst_n) begin
            ifid_clear  = 1'b1;
            idex_clear  = 1'b1;
            exmem_clear = 1'b1;
            memwb_clear = 1'b1;
        end else if (memw_c) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_hold   = 1'b1;
            exmem_hold  = 1'b1;
            memwb_clear = 1'b1;
        end else if (md_c) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_hold   = 1'b1;
            exmem_clear = 1'b1;
        end else if (br_c) begin
            ifid_clear  = 1'b1;
            idex_clear  = 1'b1;
        end else if (lu_c) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_clear  = 1'b1;
        end
    end

    // FSM, timeout and statistics; a memory wait freezes the mul/div sequence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            md_cnt       <= '0;
            md_done      <= 1'b0;
            wait_cnt     <= '0;
            mem_err      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (memw_c) begin
                if (wait_cnt == WCW'(MEM_TO - 1)) begin
                    mem_err <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + WCW'(1);
                end
            end else begin
                wait_cnt <= '0;
                md_done  <= 1'b0;
                case (state)
                    ST_RUN: begin
                        if (ex_md && !md_done) begin
                            state  <= ST_MD_WAIT;
                            md_cnt <= MCW'(MD_LAT - 2);
                        end
                    end
                    ST_MD_WAIT: begin
                        if (md_cnt == '0) begin
                            state   <= ST_RUN;
                            // masks the still-high ex_md for the cycle the op leaves EX
                            md_done <= 1'b1;
                        end else begin
                            md_cnt <= md_cnt - MCW'(1);
                        end
                    end
                    default: state <= ST_RUN;
                endcase
            end
            if (pc_hold && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed per-cycle vectors push expected controls,
// mem_err and stall_cycles into a queue; a monitor pops and compares each cycle.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        ex_memread, ex_branch_taken, ex_md, mem_req, mem_ready;
    logic        pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear;
    logic        exmem_hold, exmem_clear, memwb_clear, mem_err;
    logic [31:0] stall_cycles;

    hazard_ctrl #(.MD_LAT(4), .MEM_TO(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
        .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken), .ex_md(ex_md),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_clear(ifid_clear),
        .idex_hold(idex_hold), .idex_clear(idex_clear),
        .exmem_hold(exmem_hold), .exmem_clear(exmem_clear),
        .memwb_clear(memwb_clear), .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // {pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear, exmem_hold, exmem_clear, memwb_clear}
    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_RST  = 8'b0010_1011;
    localparam logic [7:0] C_MEMW = 8'b1101_0101;
    localparam logic [7:0] C_MD   = 8'b1101_0010;
    localparam logic [7:0] C_BR   = 8'b0010_1000;
    localparam logic [7:0] C_LU   = 8'b1100_1000;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic        err;
        logic [31:0] stall;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    compared   = 0;
    int    mismatched = 0;
    bit    stim_done  = 1'b0;
    int    exp_stall  = 0;

    // Apply one cycle of inputs and queue the response expected before the next edge
    task automatic cyc(input string nm, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] ert, input logic mr, input logic br,
                       input logic md, input logic mreq, input logic mrdy,
                       input logic [7:0] ec, input logic ee);
        exp_t e;
        id_rs = rs; id_rt = rt; ex_rt = ert; ex_memread = mr;
        ex_branch_taken = br; ex_md = md; mem_req = mreq; mem_ready = mrdy;
        if (!rst_n) exp_stall = 0;
        e.ctrl  = ec;
        e.err   = ee;
        e.stall = 32'(exp_stall);
        exp_q.push_back(e);
        name_q.push_back(nm);
        if (rst_n && ec[7]) exp_stall++;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare on the falling edge, well away from the active edge
    initial begin : monitor
        int   idle;
        int   cycles;
        exp_t e;
        string nm;
        logic [7:0] act;
        idle = 0;
        cycles = 0;
        forever begin
            @(negedge clk);
            cycles++;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                act = {pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear,
                       exmem_hold, exmem_clear, memwb_clear};
                compared++;
                if (act !== e.ctrl) begin
                    mismatched++;
                    $display("FAIL %s ctrl: got %b expected %b", nm, act, e.ctrl);
                end
                compared++;
                if (mem_err !== e.err) begin
                    mismatched++;
                    $display("FAIL %s mem_err: got %b expected %b", nm, mem_err, e.err);
                end
                compared++;
                if (stall_cycles !== e.stall) begin
                    mismatched++;
                    $display("FAIL %s stall_cycles: got %0d expected %0d", nm, stall_cycles, e.stall);
                end
            end else if (stim_done) begin
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
                $finish;
            end else begin
                idle++;
            end
            if (idle > 50 || cycles > 5000) begin
                mismatched++;
                $display("FAIL watchdog: got %0d cycles expected completion", cycles);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
                $finish;
            end
        end
    end

    initial begin : stimulus
        rst_n = 1'b0;
        id_rs = '0; id_rt = '0; ex_rt = '0;
        ex_memread = 1'b0; ex_branch_taken = 1'b0; ex_md = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset0", 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0);
        cyc("reset1", 0, 0, 0, 0, 0, 1, 1, 0, C_RST, 0);
        rst_n = 1'b1;
        cyc("idle", 1, 2, 3, 0, 0, 0, 0, 0, C_NONE, 0);

        // load-use on rs, then bubble in EX
        cyc("lu_rs", 5, 6, 5, 1, 0, 0, 0, 0, C_LU, 0);
        cyc("lu_rs_after", 5, 6, 0, 0, 0, 0, 0, 0, C_NONE, 0);
        // load to $0 never stalls
        cyc("lu_zero", 0, 0, 0, 1, 0, 0, 0, 0, C_NONE, 0);
        // load-use on rt
        cyc("lu_rt", 3, 7, 7, 1, 0, 0, 0, 0, C_LU, 0);
        cyc("lu_rt_after", 3, 7, 0, 0, 0, 0, 0, 0, C_NONE, 0);
        // load without dependency
        cyc("lu_nodep", 3, 4, 9, 1, 0, 0, 0, 0, C_NONE, 0);
        // branch beats load-use; PC not held
        cyc("br_lu", 5, 0, 5, 1, 1, 0, 0, 0, C_BR, 0);
        cyc("br_after", 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0);
        cyc("br_only", 0, 0, 0, 0, 1, 0, 0, 0, C_BR, 0);

        // mul/div: 4 stall cycles, then released while ex_md still high
        for (int i = 0; i < 4; i++) cyc("md", 0, 0, 0, 0, 0, 1, 0, 0, C_MD, 0);
        cyc("md_release", 0, 0, 0, 0, 0, 1, 0, 0, C_NONE, 0);
        cyc("md_gone", 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0);

        // mul/div interrupted by 3 memory-wait cycles: 4 + 3 stall cycles
        cyc("md5_a", 0, 0, 0, 0, 0, 1, 0, 0, C_MD, 0);
        cyc("md5_b", 0, 0, 0, 0, 0, 1, 0, 0, C_MD, 0);
        for (int i = 0; i < 3; i++) cyc("md5_memw", 0, 0, 0, 0, 0, 1, 1, 0, C_MEMW, 0);
        cyc("md5_c", 0, 0, 0, 0, 0, 1, 0, 0, C_MD, 0);
        cyc("md5_d", 0, 0, 0, 0, 0, 1, 0, 0, C_MD, 0);
        cyc("md5_release", 0, 0, 0, 0, 0, 1, 0, 0, C_NONE, 0);

        // completed access is not a wait; memory wait beats load-use
        cyc("mem_ready", 0, 0, 0, 0, 0, 0, 1, 1, C_NONE, 0);
        cyc("memw_lu", 5, 0, 5, 1, 1, 0, 1, 0, C_MEMW, 0);
        cyc("memw_lu_done", 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0);

        // 16 consecutive wait cycles raise mem_err at the 16th edge
        for (int i = 0; i < 16; i++) cyc("timeout", 0, 0, 0, 0, 0, 0, 1, 0, C_MEMW, 0);
        cyc("err_set", 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 1);
        cyc("err_sticky", 0, 0, 0, 0, 0, 0, 1, 1, C_NONE, 1);

        // reset in the middle of a mul/div stall aborts it
        cyc("md_pre_rst", 0, 0, 0, 0, 0, 1, 0, 0, C_MD, 1);
        cyc("md_pre_rst2", 0, 0, 0, 0, 0, 1, 0, 0, C_MD, 1);
        rst_n = 1'b0;
        cyc("rst_mid_md", 0, 0, 0, 0, 0, 1, 0, 0, C_RST, 0);
        rst_n = 1'b1;
        cyc("post_rst_idle", 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0);
        for (int i = 0; i < 4; i++) cyc("md_after_rst", 0, 0, 0, 0, 0, 1, 0, 0, C_MD, 0);
        cyc("md_after_rst_rel", 0, 0, 0, 0, 0, 1, 0, 0, C_NONE, 0);
        cyc("final", 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0);

        stim_done = 1'b1;
    end

endmodule
